alu_cc_unit: RTL
================

# alu_cc_unit

Parametrised, handshaked execute-stage ALU for the Y86-64 datapath. It adds an iterative unsigned multiply to ADD/SUB/AND/XOR, registers its result, and owns the architectural condition-code register (OF/ZF/SF), which updates only when requested. The block sits between decode and memory stages and supplies `cc` to the branch/cmov condition logic.

## Interface
- `N`, 64: operand/result width; must be ≥ 8.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept; a transfer occurs when `in_valid & in_ready`.
- `op`  in  3  000 ADD, 001 SUB, 010 AND, 011 XOR, 100 MUL; 101–111 illegal.
- `a`, `b`  in  N  operands; SUB computes `a − b`.
- `set_cc`  in  1  update `cc` with this op's flags.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result on `out_valid & out_ready`.
- `out`  out  N  result.
- `err`  out  1  qualifies `out`; illegal op.
- `cc`  out  3  `cc[0]`=OF, `cc[1]`=ZF, `cc[2]`=SF.

## Operation
- States: IDLE, BUSY (multiply iterating), DONE (result held).
- `in_ready` = IDLE, or (DONE and `out_ready`), which gives back-to-back single-cycle ops.
- ADD/SUB/AND/XOR/illegal: computed and registered on the accept edge, then to DONE.
- MUL: accept edge loads the iterator, then BUSY. The result is the low N bits of the unsigned product.
- Flags for each op:
  - ZF: `out == 0`.
  - SF: `out[N-1]`.
  - OF for ADD: operands have the same sign and the result sign differs.
  - OF for SUB: operand signs differ and the result sign differs from `a`.
  - OF for AND/XOR: 0.
  - OF for MUL: upper N product bits are non-zero.
- `cc` loads on the same edge `out` becomes valid, only if `set_cc` was captured high. Illegal ops never touch `cc`.
- Illegal op: `out`=0 and `err`=1. Otherwise `err`=0.
- DONE with `out_ready` low: `out`, `err` and `cc` stay stable. DONE with `out_ready` high and no new accept: return to IDLE.
- Operand wrap-around is modulo 2^N. No carry output.

## Timing
- Reset values:
  - `out_valid` 0, `out` 0, `err` 0, state IDLE.
  - `cc` = 3'b010 (ZF=1), the Y86 convention.
  - `in_ready` is 1 during reset.
- Single-cycle ops: accept at edge k, `out_valid` high after edge k.
- MUL: accept at edge k, N iteration edges k+1…k+N, `out_valid` high after edge k+N. `in_ready` is 0 throughout.
- Simultaneous drain and accept in DONE: the new result replaces the old on the same edge, and `out_valid` stays 1.
- Reset mid-operation: the state is abandoned immediately and asynchronously. Outputs take reset values. The first accept is possible on the first rising edge after `rst_n` deasserts.

## Structure
- Package `alu_pkg`:
  - op encodings as a typedef enum.
  - CC bit indices `CC_OF`, `CC_ZF`, `CC_SF`.
  - `CC_RESET` = 3'b010.
  - state enum.
- Sub-module `mul_iter`: parametrised N; radix-2 shift-add. Ports: `start`, `a`, `b`, `done`, 2N-bit `prod`. Same `clk`/`rst_n`.
- Top level holds the FSM, the combinational add/sub/logic path, flag generation and the CC register.

## Test plan
- ADD `0x7FFF_FFFF_FFFF_FFFF + 1`, `set_cc`=1 -> after 1 cycle: `out`=`0x8000_0000_0000_0000`, `cc`=3'b101, `err`=0.
- SUB 5−5 `set_cc`=1, then ADD 1+1 `set_cc`=0 on consecutive cycles with `out_ready`=1:
  - first result: `out`=0, `cc`=3'b010;
  - second result: `out`=2 on the next cycle, `cc` still 3'b010.
- MUL 3×7 -> `in_ready`=0 for N cycles, then `out`=21, `cc`=3'b000. Then MUL `2^63`×2 -> `out`=0, `cc`=3'b011.
- Backpressure: `out_ready`=0, then ADD 4+4 followed by XOR offered -> `out`=8 held stable and XOR not accepted. Raise `out_ready` -> XOR accepted on that edge.
- Reset asserted at MUL iteration 10 -> immediately `out_valid`=0, `cc`=3'b010, `in_ready`=1. A fresh ADD 2+3 after release yields 5.
- Illegal `op`=3'b111, `set_cc`=1 -> `out`=0, `err`=1, `cc` unchanged from its prior value.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the Y86-64 execute-stage ALU (alu_cc_unit):
//   - alu_op_e    : 3-bit operation encodings presented on the `op` port
//   - CC_*        : bit positions inside the 3-bit condition-code vector
//   - CC_RESET    : architectural reset value of the CC register (ZF=1)
//   - alu_state_e : handshake/iteration FSM states
//   - pack_cc     : assembles {SF, ZF, OF} into a cc vector
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100
    } alu_op_e;

    localparam int unsigned CC_OF = 0;
    localparam int unsigned CC_ZF = 1;
    localparam int unsigned CC_SF = 2;

    localparam logic [2:0] CC_RESET = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic [2:0] pack_cc(input logic of, input logic zf, input logic sf);
        logic [2:0] cc;
        cc        = '0;
        cc[CC_OF] = of;
        cc[CC_ZF] = zf;
        cc[CC_SF] = sf;
        return cc;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// ---------------------------------------------------------------------------
// mul_iter
// Radix-2 shift-add unsigned multiplier, one partial product per clock.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start      : load operands; iteration runs on the following N edges
//   a, b       : N-bit unsigned operands (sampled when start is high)
//   done       : high during the cycle whose closing edge is the last
//                iteration; prod is the final product in that cycle
//   prod       : 2N-bit product value that the accumulator takes on the
//                next edge (equals a*b while done is high)
// ---------------------------------------------------------------------------
module mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] prod
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_next;

    // Exposing the next accumulator value lets the consumer register the
    // product on the final iteration edge instead of one cycle later.
    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{N{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(N);
        end else if (cnt_q != '0) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done = (cnt_q == CW'(1));
    assign prod = acc_next;

endmodule

// File: rtl/alu_cc_unit.sv
// ---------------------------------------------------------------------------
// alu_cc_unit
// Handshaked Y86-64 execute-stage ALU with registered result and the
// architectural condition-code register.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operation handshake; transfer on both high
//   op                  : 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 MUL,
//                         101..111 illegal (err=1, out=0, cc untouched)
//   a, b                : N-bit operands (SUB is a - b)
//   set_cc              : load cc with this operation's flags
//   out_valid/out_ready : result handshake; result held while stalled
//   out, err            : registered result and illegal-op qualifier
//   cc                  : {SF, ZF, OF}
// ---------------------------------------------------------------------------
module alu_cc_unit
    import alu_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         set_cc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         err,
    output logic [2:0]   cc
);

    alu_state_e   state_q, state_d;
    logic [N-1:0] out_q, out_d;
    logic         err_q, err_d;
    logic [2:0]   cc_q, cc_d;
    logic         out_valid_q, out_valid_d;
    logic         set_cc_q, set_cc_d;

    alu_op_e      op_e;
    logic         accept;
    logic [N-1:0] alu_res;
    logic         alu_of;
    logic         alu_legal;
    logic [2:0]   alu_cc;
    logic [2:0]   mul_cc;

    logic           mul_start;
    logic           mul_done;
    logic [2*N-1:0] mul_prod;

    mul_iter #(.N(N)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    assign op_e     = alu_op_e'(op);
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath and its flags.
    always_comb begin
        alu_res   = '0;
        alu_of    = 1'b0;
        alu_legal = 1'b1;
        case (op_e)
            OP_ADD: begin
                alu_res = a + b;
                alu_of  = (a[N-1] == b[N-1]) && (alu_res[N-1] != a[N-1]);
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_of  = (a[N-1] != b[N-1]) && (alu_res[N-1] != a[N-1]);
            end
            OP_AND: alu_res = a & b;
            OP_XOR: alu_res = a ^ b;
            OP_MUL: alu_res = '0;
            default: alu_legal = 1'b0;
        endcase
        alu_cc = pack_cc(alu_of, alu_res == '0, alu_res[N-1]);
    end

    // Multiply flags: OF flags any significance lost in the upper half.
    always_comb begin
        mul_cc = pack_cc(|mul_prod[2*N-1:N], mul_prod[N-1:0] == '0, mul_prod[N-1]);
    end

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        err_d       = err_q;
        cc_d        = cc_q;
        out_valid_d = out_valid_q;
        set_cc_d    = set_cc_q;
        mul_start   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (op_e == OP_MUL) begin
                        mul_start   = 1'b1;
                        set_cc_d    = set_cc;
                        state_d     = ST_BUSY;
                        out_valid_d = 1'b0;
                    end else begin
                        out_d       = alu_res;
                        err_d       = !alu_legal;
                        if (alu_legal && set_cc) begin
                            cc_d = alu_cc;
                        end
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    out_d       = mul_prod[N-1:0];
                    err_d       = 1'b0;
                    if (set_cc_q) begin
                        cc_d = mul_cc;
                    end
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            err_q       <= 1'b0;
            cc_q        <= CC_RESET;
            out_valid_q <= 1'b0;
            set_cc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            err_q       <= err_d;
            cc_q        <= cc_d;
            out_valid_q <= out_valid_d;
            set_cc_q    <= set_cc_d;
        end
    end

    assign out       = out_q;
    assign err       = err_q;
    assign cc        = cc_q;
    assign out_valid = out_valid_q;

endmodule
